// File: rtl/alu_muldiv_pkg.sv
// Shared M-extension opcode space and decode for the multi-cycle mul/div unit.
package alu_muldiv_pkg;

  // M-extension codes sit above the base ALU codes in the same 6-bit space.
  localparam int ALU_MUL    = 32;
  localparam int ALU_MULH   = 33;
  localparam int ALU_MULHSU = 34;
  localparam int ALU_MULHU  = 35;
  localparam int ALU_DIV    = 36;
  localparam int ALU_DIVU   = 37;
  localparam int ALU_REM    = 38;
  localparam int ALU_REMU   = 39;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef struct packed {
    logic   vld;
    md_op_e op;
  } md_dec_t;

  // Map an alucode onto an internal op; vld=0 for anything outside the M set.
  function automatic md_dec_t md_decode(input int code);
    md_dec_t d;
    d.vld = 1'b1;
    d.op  = MD_MUL;
    case (code)
      ALU_MUL:    d.op = MD_MUL;
      ALU_MULH:   d.op = MD_MULH;
      ALU_MULHSU: d.op = MD_MULHSU;
      ALU_MULHU:  d.op = MD_MULHU;
      ALU_DIV:    d.op = MD_DIV;
      ALU_DIVU:   d.op = MD_DIVU;
      ALU_REM:    d.op = MD_REM;
      ALU_REMU:   d.op = MD_REMU;
      default:    d.vld = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 iterative core: shift-add multiply / restoring divide,
// one bit per cycle over a 2*XLEN accumulator.
//  multiply: acc = {product_hi, product_lo}
//  divide:   acc = {remainder, quotient}
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kill,
  input  logic              is_div,
  input  logic [XLEN-1:0]   opa,     // multiplicand / dividend
  input  logic [XLEN-1:0]   opb,     // multiplier / divisor
  output logic              last,    // this cycle performs the final step
  output logic [2*XLEN-1:0] acc_nxt  // accumulator after this cycle's step
);

  localparam int CNTW = $clog2(XLEN);

  logic              run_q, run_d;
  logic              div_q, div_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] step;

  // One iteration of whichever algorithm is loaded.
  always_comb begin
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    ge      = rem_sh >= {1'b0, m_q};
    rem_new = ge ? XLEN'(rem_sh - {1'b0, m_q}) : rem_sh[XLEN-1:0];
    if (div_q) step = {rem_new, acc_q[XLEN-2:0], ge};
    else       step = {sum, acc_q[XLEN-1:1]};
  end

  assign acc_nxt = step;
  assign last    = run_q && (cnt_q == '0);

  // Load on start, step while running; kill drops the op.
  always_comb begin
    run_d = run_q;
    div_d = div_q;
    cnt_d = cnt_q;
    m_d   = m_q;
    acc_d = acc_q;
    if (start) begin
      run_d = 1'b1;
      div_d = is_div;
      cnt_d = CNTW'(XLEN-1);
      m_d   = is_div ? opb : opa;
      acc_d = {{XLEN{1'b0}}, (is_div ? opa : opb)};
    end else if (run_q) begin
      acc_d = step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        run_d = 1'b0;
        cnt_d = '0;
      end
    end
    if (kill) begin
      run_d = 1'b0;
      cnt_d = '0;
    end
  end

  // Core state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      m_q   <= '0;
      acc_q <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      m_q   <= m_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// RV32M multi-cycle unit: handshake, sign pre/post-processing, fast path for
// RISC-V corner cases, flush. Iteration itself lives in muldiv_iter_core.
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int CW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   alucode,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  import alu_muldiv_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  md_op_e          op_q, op_d;
  logic            neg_q, neg_d;    // product / quotient sign
  logic            rsgn_q, rsgn_d;  // remainder sign = dividend sign
  logic [XLEN-1:0] result_q, result_d;

  md_dec_t           dec;
  logic              is_div_in, sgn1_in, sgn2_in, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, ovf, fast, accept;
  logic [XLEN-1:0]   fast_res, post_res;
  logic              core_start, core_last;
  logic [2*XLEN-1:0] acc_nxt, prod_s;
  logic [XLEN-1:0]   quot, rem;

  // Decode the request and strip signs so the core only sees magnitudes.
  always_comb begin
    dec       = md_decode(int'(alucode));
    is_div_in = dec.op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    sgn1_in   = dec.op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    sgn2_in   = dec.op inside {MD_MULH, MD_DIV, MD_REM};
    a_neg     = sgn1_in & op1[XLEN-1];
    b_neg     = sgn2_in & op2[XLEN-1];
    a_mag     = a_neg ? -op1 : op1;
    b_mag     = b_neg ? -op2 : op2;
    div_zero  = dec.vld && is_div_in && (op2 == '0);
    ovf       = dec.vld && (dec.op inside {MD_DIV, MD_REM}) &&
                (op1 == MIN_INT) && (op2 == '1);
    fast      = !dec.vld || div_zero || ovf;
    fast_res  = '0;
    if (!dec.vld)     fast_res = '0;
    else if (div_zero) fast_res = (dec.op inside {MD_DIV, MD_DIVU}) ? '1 : op1;
    else if (ovf)      fast_res = (dec.op == MD_DIV) ? op1 : '0;
  end

  // Re-apply signs to the finished core result.
  always_comb begin
    prod_s = neg_q ? -acc_nxt : acc_nxt;
    quot   = acc_nxt[XLEN-1:0];
    rem    = acc_nxt[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                       post_res = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: post_res = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              post_res = neg_q ? -quot : quot;
      MD_REM, MD_REMU:              post_res = rsgn_q ? -rem : rem;
      default:                      post_res = '0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && in_valid && !flush;

  // FSM next-state: IDLE -> CALC|DONE -> IDLE, flush wins over everything.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_d      = neg_q;
    rsgn_d     = rsgn_q;
    result_d   = result_q;
    core_start = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d   = dec.op;
        neg_d  = a_neg ^ b_neg;
        rsgn_d = a_neg;
        if (fast) begin
          result_d = fast_res;
          state_d  = S_DONE;
        end else begin
          core_start = 1'b1;
          state_d    = S_CALC;
        end
      end
      S_CALC: if (core_last) begin
        result_d = post_res;
        state_d  = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      rsgn_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rsgn_q   <= rsgn_d;
      result_q <= result_d;
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .kill    (flush),
    .is_div  (is_div_in),
    .opa     (a_mag),
    .opb     (b_mag),
    .last    (core_last),
    .acc_nxt (acc_nxt)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised + directed bench for alu_muldiv against a plain-arithmetic model.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int CW   = 6;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [CW-1:0]   alucode;
  logic [XLEN-1:0] op1, op2, result;
  int              n_chk = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(XLEN), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alucode(alucode), .op1(op1), .op2(op2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics via 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input int code, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (code)
      ALU_MUL:    begin p = ua * ub; return p[31:0];  end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32'($signed(a) % $signed(b));
      end
      ALU_REMU: return (b == 0) ? a : a % b;
      default:  return 0;
    endcase
  endfunction

  // Cycles from accept to first out_valid.
  function automatic int ref_lat(input int code, input logic [31:0] a, input logic [31:0] b);
    if (code < ALU_MUL || code > ALU_REMU) return 1;
    if (code >= ALU_DIV && b == 0) return 1;
    if ((code == ALU_DIV || code == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Issue one op, check latency, result and handshake, then retire it.
  task automatic run_op(input int code, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    alucode = code[CW-1:0]; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
    chk({tag, ".lat"}, lat, ref_lat(code, a, b));
    chk({tag, ".res"}, result, ref_md(code, a, b));
    chk({tag, ".busy_ready"}, {busy, in_ready}, 2'b10);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".idle"}, {busy, out_valid}, 2'b00);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold_res;
    int c0, c1, seen, lat;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alucode = '0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.flags", {in_ready, out_valid, busy}, 3'b100);
    chk("reset.result", result, 0);

    // Directed cases
    run_op(ALU_MUL,    32'd7,         32'hFFFF_FFFD, "mul_7x-3");
    run_op(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    run_op(ALU_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_min");
    run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(ALU_DIV,    32'hFFFF_FFF9, 32'd2,         "div_-7_2");
    run_op(ALU_REM,    32'hFFFF_FFF9, 32'd2,         "rem_-7_2");
    run_op(ALU_DIVU,   32'd100,       32'd7,         "divu_100_7");
    run_op(ALU_REMU,   32'd100,       32'd7,         "remu_100_7");
    run_op(ALU_DIVU,   32'd5,         32'd0,         "divu_by0");
    run_op(ALU_REMU,   32'd5,         32'd0,         "remu_by0");
    run_op(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3,          32'd5,         32'd6,         "unsupported");

    // Consumer stall: result held 10 cycles in DONE
    @(negedge clk);
    alucode = ALU_DIVU; op1 = 32'd1000; op2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
    chk("stall.lat", lat, XLEN + 1);
    hold_res = ref_md(ALU_DIVU, 32'd1000, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall.hold", {out_valid, in_ready, result}, {2'b10, hold_res});
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("stall.release", {in_ready, out_valid, busy}, 3'b100);

    // Flush at T+5 of a DIV, then a fresh MUL
    @(negedge clk);
    alucode = ALU_DIV; op1 = 32'hFFFF_FF9C; op2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush.idle", {in_ready, out_valid, busy}, 3'b100);
    run_op(ALU_MUL, 32'd3, 32'd4, "post_flush_mul");

    // Flush together with in_valid in IDLE: not accepted
    @(negedge clk);
    alucode = ALU_MUL; op1 = 32'd9; op2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 begin in_valid = 1'b0; flush = 1'b0; end
    seen = 0;
    repeat (40) begin @(negedge clk); seen |= {31'b0, out_valid | busy}; end
    chk("flush_in.no_accept", seen, 0);

    // Reset at T+10 of a MULHU
    @(negedge clk);
    alucode = ALU_MULHU; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.flags", {in_ready, out_valid, busy}, 3'b100);
    chk("rst_mid.result", result, 0);
    seen = 0;
    repeat (40) begin @(negedge clk); seen |= {31'b0, out_valid}; end
    chk("rst_mid.quiet", seen, 0);

    // Back-to-back throughput with in_valid/out_ready held high
    out_ready = 1'b1;
    alucode = ALU_MUL; op1 = 32'd2; op2 = 32'd3; in_valid = 1'b1;
    c0 = -1; c1 = -1;
    for (int i = 0; i < 100 && c1 < 0; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (c0 < 0) c0 = i;
        else        c1 = i;
      end
    end
    in_valid = 1'b0;
    chk("b2b.period", c1 - c0, XLEN + 2);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("b2b.idle", busy, 0);

    // Randomised ops against the model
    for (int n = 0; n < 80; n++) begin
      int code;
      int pick;
      pick = $urandom_range(0, 9);
      if (pick < 8)       code = ALU_MUL + pick;
      else if (pick == 8) code = $urandom_range(0, 31);
      else                code = 63;
      run_op(code, rnd_opnd(), rnd_opnd(), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
